aux_uart_boot_loader: RTL and testbench

AUX_UART_BOOT_LOADER -- requirements
Module: aux_uart_boot_loader

---
 rtl/aux_uart_boot_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_aux_uart_boot_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_uart_boot_loader.sv
// UART (8N1) boot loader: streams a little-endian word image into program memory, then releases the MCU.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before boot is accepted.
module aux_uart_boot_loader #(
   parameter int unsigned CLK_FREQUENCY = 50000000,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned N_WORDS       = 1024,
   parameter int unsigned TIMEOUT_BITS  = 1000,
   localparam int unsigned ADDR_W       = $clog2(N_WORDS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset_n,
   output logic              boot_done,
   output logic              boot_error,
   output logic              frame_error
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TO_W         = $clog2(TO_CYCLES + 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_WORDS - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [1:0] {LdLoad, LdCheck, LdDone, LdError} ld_state_e;
`else
   typedef enum logic [1:0] {LdLoad, LdDone, LdError} ld_state_e;
`endif

   // Receiver
   rx_state_e        rx_state_q, rx_state_d;
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_error_q, frame_error_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_prev_q     <= 1'b1;
         rx_state_q    <= RxIdle;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         byte_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         rx_meta_q     <= rx;
         rx_sync_q     <= rx_meta_q;
         rx_prev_q     <= rx_sync_q;
         rx_state_q    <= rx_state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         byte_valid_q  <= byte_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   always_comb begin
      rx_state_d    = rx_state_q;
      cnt_d         = cnt_q + 1'b1;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      byte_valid_d  = 1'b0;
      frame_error_d = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
         end
         RxStart: if (cnt_q == HALF_LAST) begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            rx_state_d = rx_sync_q ? RxIdle : RxData;
         end
         RxData: if (cnt_q == BIT_LAST) begin
            cnt_d     = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_d = RxStop;
         end
         RxStop: if (cnt_q == BIT_LAST) begin
            cnt_d      = '0;
            rx_state_d = RxIdle;
            if (rx_sync_q) byte_valid_d = 1'b1;
            else           frame_error_d = 1'b1;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Loader
   ld_state_e         ld_state_q, ld_state_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [23:0]       data_q, data_d;
   logic              got_byte_q, got_byte_d;
   logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              boot_done_q, boot_error_q;
   logic              rx_active, timeout;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        xor_q, xor_d;
`endif

   // Any line activity (low level or a byte in flight) restarts the idle timer.
   assign rx_active = (rx_state_q != RxIdle) || !rx_sync_q;
   assign timeout   = got_byte_q && !rx_active && (idle_cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ld_state_q   <= LdLoad;
         byte_idx_q   <= '0;
         word_cnt_q   <= '0;
         data_q       <= '0;
         got_byte_q   <= 1'b0;
         idle_cnt_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         boot_done_q  <= 1'b0;
         boot_error_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         xor_q        <= '0;
`endif
      end else begin
         ld_state_q   <= ld_state_d;
         byte_idx_q   <= byte_idx_d;
         word_cnt_q   <= word_cnt_d;
         data_q       <= data_d;
         got_byte_q   <= got_byte_d;
         idle_cnt_q   <= idle_cnt_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         boot_done_q  <= (ld_state_q == LdDone);
         boot_error_q <= (ld_state_q == LdError);
`ifdef BOOT_CHECKSUM_EN
         xor_q        <= xor_d;
`endif
      end
   end

   always_comb begin
      ld_state_d  = ld_state_q;
      byte_idx_d  = byte_idx_q;
      word_cnt_d  = word_cnt_q;
      data_d      = data_q;
      got_byte_d  = got_byte_q;
      mem_we_d    = 1'b0;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
      xor_d       = xor_q;
`endif
      if (rx_active || !got_byte_q) idle_cnt_d = '0;
      else if (idle_cnt_q != TO_LAST) idle_cnt_d = idle_cnt_q + 1'b1;
      else idle_cnt_d = idle_cnt_q;

      case (ld_state_q)
         LdLoad: begin
            if (byte_valid_q) begin
               got_byte_d = 1'b1;
`ifdef BOOT_CHECKSUM_EN
               xor_d      = xor_q ^ shift_q;
`endif
               if (byte_idx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_waddr_d = word_cnt_q;
                  mem_wdata_d = {shift_q, data_q};
                  byte_idx_d  = '0;
                  if (word_cnt_q == ADDR_LAST) begin
`ifdef BOOT_CHECKSUM_EN
                     ld_state_d = LdCheck;
`else
                     ld_state_d = LdDone;
`endif
                  end else begin
                     word_cnt_d = word_cnt_q + 1'b1;
                  end
               end else begin
                  case (byte_idx_q)
                     2'd0:    data_d[7:0]   = shift_q;
                     2'd1:    data_d[15:8]  = shift_q;
                     default: data_d[23:16] = shift_q;
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end else if (timeout) begin
               ld_state_d = LdError;
            end
         end
`ifdef BOOT_CHECKSUM_EN
         LdCheck: begin
            if (byte_valid_q) ld_state_d = (shift_q == xor_q) ? LdDone : LdError;
            else if (timeout) ld_state_d = LdError;
         end
`endif
         LdDone, LdError: ;
         default: ld_state_d = LdLoad;
      endcase
   end

   assign mem_we      = mem_we_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_wdata   = mem_wdata_q;
   assign boot_done   = boot_done_q;
   assign cpu_reset_n = boot_done_q;
   assign boot_error  = boot_error_q;
   assign frame_error = frame_error_q;

endmodule

// File: tb/tb_aux_uart_boot_loader.sv
// Self-checking bench for aux_uart_boot_loader: 10 clocks per bit, 4-word image, 20-bit timeout.
module tb_aux_uart_boot_loader;

   localparam int unsigned CPB = 10;
   typedef logic [33:0] wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic        mem_we;
   logic [1:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        cpu_reset_n, boot_done, boot_error, frame_error;

   int checks = 0;
   int errors = 0;

   wr_t exp_q[$];
   wr_t got_q[$];
   int  got_rd = 0;
   int  cyc = 0;
   int  last_we_cyc = 0;
   int  done_cyc = 0;
   int  fe_count = 0;
   int  fe_long = 0;
   logic fe_prev = 1'b0;
   logic done_prev = 1'b0;

   aux_uart_boot_loader #(
      .CLK_FREQUENCY(1000000),
      .BAUD_RATE    (100000),
      .N_WORDS      (4),
      .TIMEOUT_BITS (20)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .cpu_reset_n(cpu_reset_n),
      .boot_done  (boot_done),
      .boot_error (boot_error),
      .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   // Observed writes and pulses, captured away from the active edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (reset_n && mem_we) begin
         got_q.push_back({mem_waddr, mem_wdata});
         last_we_cyc <= cyc;
      end
      if (reset_n && frame_error) fe_count <= fe_count + 1;
      if (reset_n && frame_error && fe_prev) fe_long <= fe_long + 1;
      fe_prev <= frame_error;
      if (reset_n && boot_done && !done_prev) done_cyc <= cyc;
      done_prev <= boot_done;
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      checks++; if (mem_waddr !== 2'd0) begin errors++; $display("FAIL reset_mem_waddr got %0d want 0", mem_waddr); end
      checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
      checks++; if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_reset_n got %b want 0", cpu_reset_n); end
      checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL reset_boot_done got %b want 0", boot_done); end
      checks++; if (boot_error !== 1'b0) begin errors++; $display("FAIL reset_boot_error got %b want 0", boot_error); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
      repeat (300) @(negedge clk);
      checks++; if (boot_error !== 1'b0) begin errors++; $display("FAIL no_timeout_before_byte got %b want 0", boot_error); end
   endtask

   task automatic test_single_word();
      wr_t e;
      do_reset();
      exp_q.push_back({2'd0, 32'h12345678});
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_rd >= got_q.size()) begin errors++; $display("FAIL single_word_missing got none want %h", e); end
         else begin
            if (got_q[got_rd] !== e) begin errors++; $display("FAIL single_word got %h want %h", got_q[got_rd], e); end
            got_rd++;
         end
      end
      checks++; if (got_q.size() != got_rd) begin errors++; $display("FAIL single_word_extra got %0d want %0d", got_q.size(), got_rd); got_rd = got_q.size(); end
      checks++; if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL single_word_cpu_reset_n got %b want 0", cpu_reset_n); end
   endtask

   task automatic send_image();
      for (int w = 0; w < 4; w++) begin
         exp_q.push_back({w[1:0], 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
         for (int k = 0; k < 4; k++) send_byte(8'(4*w+k), 1'b1);
      end
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum();
      wr_t e;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         send_image();
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_rd >= got_q.size()) begin errors++; $display("FAIL csum_missing got none want %h", e); end
            else begin
               if (got_q[got_rd] !== e) begin errors++; $display("FAIL csum_write got %h want %h", got_q[got_rd], e); end
               got_rd++;
            end
         end
         checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL csum_early_done got %b want 0", boot_done); end
         send_byte(8'(pass), 1'b1);
         repeat (5) @(negedge clk);
         checks++; if (boot_done !== (pass == 0)) begin errors++; $display("FAIL csum_done got %b want %b", boot_done, pass == 0); end
         checks++; if (boot_error !== (pass == 1)) begin errors++; $display("FAIL csum_error got %b want %b", boot_error, pass == 1); end
         checks++; if (cpu_reset_n !== (pass == 0)) begin errors++; $display("FAIL csum_cpu_reset_n got %b want %b", cpu_reset_n, pass == 0); end
      end
   endtask
`else
   task automatic test_full_image();
      wr_t e;
      int  n_before;
      do_reset();
      send_image();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_rd >= got_q.size()) begin errors++; $display("FAIL image_missing got none want %h", e); end
         else begin
            if (got_q[got_rd] !== e) begin errors++; $display("FAIL image_write got %h want %h", got_q[got_rd], e); end
            got_rd++;
         end
      end
      checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL image_boot_done got %b want 1", boot_done); end
      checks++; if (cpu_reset_n !== 1'b1) begin errors++; $display("FAIL image_cpu_reset_n got %b want 1", cpu_reset_n); end
      checks++; if (done_cyc - last_we_cyc != 1) begin errors++; $display("FAIL image_done_latency got %0d want 1", done_cyc - last_we_cyc); end
      n_before = got_q.size();
      send_byte(8'h10, 1'b1);
      checks++; if (got_q.size() != n_before) begin errors++; $display("FAIL image_17th_write got %0d want %0d", got_q.size(), n_before); got_rd = got_q.size(); end
      checks++; if (boot_done !== 1'b1) begin errors++; $display("FAIL image_done_sticky got %b want 1", boot_done); end
   endtask
`endif

   task automatic test_frame_error();
      wr_t e;
      int  fe0, fl0;
      do_reset();
      fe0 = fe_count;
      fl0 = fe_long;
      send_byte(8'hA5, 1'b0);
      checks++; if (fe_count - fe0 != 1) begin errors++; $display("FAIL frame_error_pulses got %0d want 1", fe_count - fe0); end
      checks++; if (fe_long != fl0) begin errors++; $display("FAIL frame_error_width got %0d long want 0", fe_long - fl0); end
      exp_q.push_back({2'd0, 32'hDDCCBBAA});
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_rd >= got_q.size()) begin errors++; $display("FAIL frame_word_missing got none want %h", e); end
         else begin
            if (got_q[got_rd] !== e) begin errors++; $display("FAIL frame_word got %h want %h", got_q[got_rd], e); end
            got_rd++;
         end
      end
   endtask

   task automatic test_glitch();
      wr_t e;
      int  fe0;
      do_reset();
      fe0 = fe_count;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (50) @(negedge clk);
      checks++; if (fe_count != fe0) begin errors++; $display("FAIL glitch_frame_error got %0d want 0", fe_count - fe0); end
      exp_q.push_back({2'd0, 32'h0403_0201});
      for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_rd >= got_q.size()) begin errors++; $display("FAIL glitch_word_missing got none want %h", e); end
         else begin
            if (got_q[got_rd] !== e) begin errors++; $display("FAIL glitch_word got %h want %h", got_q[got_rd], e); end
            got_rd++;
         end
      end
   endtask

   task automatic test_timeout();
      int waited;
      do_reset();
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      checks++; if (boot_error !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", boot_error); end
      waited = 0;
      while (boot_error !== 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (boot_error !== 1'b1) begin errors++; $display("FAIL timeout_error got %b want 1", boot_error); end
      checks++; if (waited < 150 || waited > 220) begin errors++; $display("FAIL timeout_delay got %0d want 150..220", waited); end
      checks++; if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL timeout_cpu_reset_n got %b want 0", cpu_reset_n); end
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      checks++; if (got_q.size() != got_rd) begin errors++; $display("FAIL timeout_write got %0d want %0d", got_q.size(), got_rd); got_rd = got_q.size(); end
      checks++; if (boot_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", boot_error); end
   endtask

   task automatic test_reset_mid_byte();
      wr_t        e;
      logic [7:0] b;
      logic [41:0] outs;
      do_reset();
      send_byte(8'hF1, 1'b1);
      send_byte(8'hF2, 1'b1);
      b = 8'hF3;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = b[4];
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      outs = {mem_we, mem_waddr, mem_wdata, cpu_reset_n, boot_done, boot_error, frame_error, 3'b000};
      checks++; if (outs !== 42'd0) begin errors++; $display("FAIL mid_byte_reset_outputs got %h want 0", outs); end
      rx = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      exp_q.push_back({2'd0, 32'hC4B3A291});
      send_byte(8'h91, 1'b1);
      send_byte(8'hA2, 1'b1);
      send_byte(8'hB3, 1'b1);
      send_byte(8'hC4, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_rd >= got_q.size()) begin errors++; $display("FAIL mid_byte_word_missing got none want %h", e); end
         else begin
            if (got_q[got_rd] !== e) begin errors++; $display("FAIL mid_byte_word got %h want %h", got_q[got_rd], e); end
            got_rd++;
         end
      end
      checks++; if (got_q.size() != got_rd) begin errors++; $display("FAIL mid_byte_extra got %0d want %0d", got_q.size(), got_rd); end
   endtask

   initial begin
      test_reset();
      test_single_word();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`else
      test_full_image();
`endif
      test_frame_error();
      test_glitch();
      test_timeout();
      test_reset_mid_byte();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
